// File: rtl/segre_pkg.sv
// -----------------------------------------------------------------------------
// segre_pkg
// Shared types and constants for the memory stage.
//   WORD_SIZE           : data/address width
//   REG_SIZE            : register-file address width
//   MEM_TIMEOUT_DEFAULT : default cycles to wait for a memory ack
//   memop_type_e        : access size (BYTE/HALF/WORD)
//   mem_state_e         : memory-stage FSM states (IDLE/REQ)
// -----------------------------------------------------------------------------
package segre_pkg;

  localparam int WORD_SIZE           = 32;
  localparam int REG_SIZE            = 5;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/segre_mem_align.sv
// -----------------------------------------------------------------------------
// segre_mem_align
// Combinational lane logic for the memory stage.
//   type_i     : access size
//   addr_lo_i  : low two address bits (byte offset within the word)
//   sign_ext_i : sign-extend narrow loads
//   st_data_i  : store data (rs2)
//   rdata_i    : raw word returned by memory
//   be_o       : byte enables for the access
//   wdata_o    : store data replicated across all lanes of its size
//   ld_data_o  : load data shifted down to bit 0 and extended
// -----------------------------------------------------------------------------
module segre_mem_align
  import segre_pkg::*;
(
  input  memop_type_e          type_i,
  input  logic [1:0]           addr_lo_i,
  input  logic                 sign_ext_i,
  input  logic [WORD_SIZE-1:0] st_data_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] ld_data_o
);

  logic [WORD_SIZE-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    shifted   = rdata_i;
    ld_data_o = rdata_i;
    case (type_i)
      BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        ld_data_o = {{(WORD_SIZE-8){sign_ext_i & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        // Only addr[1] selects the halfword; addr[0] is ignored.
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {2{st_data_i[15:0]}};
        shifted   = rdata_i >> {addr_lo_i[1], 4'b0000};
        ld_data_o = {{(WORD_SIZE-16){sign_ext_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/segre_mem_stage.sv
// -----------------------------------------------------------------------------
// segre_mem_stage
// Memory pipeline stage: issues loads/stores on a req/ack port, stalls the
// upstream stages while a request is outstanding, and forwards ALU results
// and branch redirects to writeback with one cycle of latency.
//   clk_i, rsn_i          : clock, asynchronous active-low reset
//   alu_res_i .. new_pc_i : registered EX-stage outputs
//   mem_*_o / mem_*_i     : data-memory request port
//   hazard_o              : combinational stall for EX and earlier
//   wb_*_o                : writeback results
//   tkbr_o, new_pc_o      : branch redirect to fetch
//   bus_err_o             : one-cycle pulse when a request times out
//   misaligned_o          : one-cycle pulse on a trapped misaligned access
// Build option: define SEGRE_MEM_MISALIGN_TRAP_EN to trap misaligned
// HALF/WORD accesses instead of issuing them.
// -----------------------------------------------------------------------------
module segre_mem_stage
  import segre_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  memop_type_e          memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic                 tkbr_i,
  input  logic [WORD_SIZE-1:0] new_pc_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic                 hazard_o,
  output logic [WORD_SIZE-1:0] wb_res_o,
  output logic                 wb_rf_we_o,
  output logic [REG_SIZE-1:0]  wb_rf_waddr_o,
  output logic                 tkbr_o,
  output logic [WORD_SIZE-1:0] new_pc_o,
  output logic                 bus_err_o,
  output logic                 misaligned_o
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_e           state_q;
  logic [7:0]           cnt_q;
  memop_type_e          type_q;
  logic [1:0]           addr_lo_q;
  logic                 sign_ext_q;
  logic                 is_load_q;
  logic [REG_SIZE-1:0]  waddr_q;

  logic                 memop;
  logic                 misaligned;
  logic                 start_req;
  logic                 in_req;
  logic                 ack_hit;
  logic                 timeout_hit;

  memop_type_e          align_type;
  logic [1:0]           align_addr_lo;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] ld_data;

  assign memop = memop_rd_i | memop_wr_i;

`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
  assign misaligned = memop &&
                      (((memop_type_i == HALF) && alu_res_i[0]) ||
                       ((memop_type_i == WORD) && (alu_res_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign in_req      = (state_q == REQ);
  assign start_req   = (state_q == IDLE) && memop && !misaligned;
  assign ack_hit     = in_req && mem_ack_i;
  assign timeout_hit = in_req && !mem_ack_i && (cnt_q == TO_LAST);

  // Stall while issuing or waiting; released in the ack/timeout cycle so EX
  // advances at that same edge. Forced low while reset is asserted.
  assign hazard_o = rsn_i & (start_req | (in_req & !ack_hit & !timeout_hit));

  // Store lanes come from the incoming op; load extraction uses the
  // captured access once the request is outstanding.
  assign align_type    = in_req ? type_q    : memop_type_i;
  assign align_addr_lo = in_req ? addr_lo_q : alu_res_i[1:0];

  segre_mem_align u_align (
    .type_i     (align_type),
    .addr_lo_i  (align_addr_lo),
    .sign_ext_i (sign_ext_q),
    .st_data_i  (rf_st_data_i),
    .rdata_i    (mem_rdata_i),
    .be_o       (be),
    .wdata_o    (wdata),
    .ld_data_o  (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      type_q        <= BYTE;
      addr_lo_q     <= '0;
      sign_ext_q    <= 1'b0;
      is_load_q     <= 1'b0;
      waddr_q       <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_be_o      <= '0;
      wb_res_o      <= '0;
      wb_rf_we_o    <= 1'b0;
      wb_rf_waddr_o <= '0;
      tkbr_o        <= 1'b0;
      new_pc_o      <= '0;
      bus_err_o     <= 1'b0;
      misaligned_o  <= 1'b0;
    end else begin
      bus_err_o    <= 1'b0;
      misaligned_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!memop) begin
            wb_res_o      <= alu_res_i;
            wb_rf_we_o    <= rf_we_i;
            wb_rf_waddr_o <= rf_waddr_i;
            tkbr_o        <= tkbr_i;
            new_pc_o      <= new_pc_i;
          end else begin
            wb_rf_we_o <= 1'b0;
            tkbr_o     <= 1'b0;
            if (misaligned) begin
              misaligned_o <= 1'b1;
            end else begin
              type_q      <= memop_type_i;
              addr_lo_q   <= alu_res_i[1:0];
              sign_ext_q  <= memop_sign_ext_i;
              is_load_q   <= !memop_wr_i;  // rd+wr together acts as a store
              waddr_q     <= rf_waddr_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= memop_wr_i;
              mem_addr_o  <= {alu_res_i[WORD_SIZE-1:2], 2'b00};
              mem_wdata_o <= wdata;
              mem_be_o    <= be;
              cnt_q       <= '0;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          tkbr_o <= 1'b0;
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            wb_rf_we_o <= is_load_q;
            if (is_load_q) begin
              wb_res_o      <= ld_data;
              wb_rf_waddr_o <= waddr_q;
            end
            state_q <= IDLE;
          end else if (cnt_q == TO_LAST) begin
            mem_req_o  <= 1'b0;
            wb_rf_we_o <= 1'b0;
            bus_err_o  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            wb_rf_we_o <= 1'b0;
            cnt_q      <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_segre_mem_stage
// Scoreboard bench for segre_mem_stage (default build, MEM_TIMEOUT=4).
// Stimulus pushes expected memory requests and writeback events into queues;
// a monitor pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_segre_mem_stage;
  import segre_pkg::*;

  localparam int TO = 4;

  logic                 clk_i = 1'b0;
  logic                 rsn_i;
  logic [WORD_SIZE-1:0] alu_res_i;
  logic                 rf_we_i;
  logic [REG_SIZE-1:0]  rf_waddr_i;
  logic [WORD_SIZE-1:0] rf_st_data_i;
  memop_type_e          memop_type_i;
  logic                 memop_rd_i;
  logic                 memop_wr_i;
  logic                 memop_sign_ext_i;
  logic                 tkbr_i;
  logic [WORD_SIZE-1:0] new_pc_i;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [WORD_SIZE-1:0] mem_addr_o;
  logic [WORD_SIZE-1:0] mem_wdata_o;
  logic [3:0]           mem_be_o;
  logic [WORD_SIZE-1:0] mem_rdata_i;
  logic                 mem_ack_i;
  logic                 hazard_o;
  logic [WORD_SIZE-1:0] wb_res_o;
  logic                 wb_rf_we_o;
  logic [REG_SIZE-1:0]  wb_rf_waddr_o;
  logic                 tkbr_o;
  logic [WORD_SIZE-1:0] new_pc_o;
  logic                 bus_err_o;
  logic                 misaligned_o;

  segre_mem_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk_i            (clk_i),
    .rsn_i            (rsn_i),
    .alu_res_i        (alu_res_i),
    .rf_we_i          (rf_we_i),
    .rf_waddr_i       (rf_waddr_i),
    .rf_st_data_i     (rf_st_data_i),
    .memop_type_i     (memop_type_i),
    .memop_rd_i       (memop_rd_i),
    .memop_wr_i       (memop_wr_i),
    .memop_sign_ext_i (memop_sign_ext_i),
    .tkbr_i           (tkbr_i),
    .new_pc_i         (new_pc_i),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_ack_i        (mem_ack_i),
    .hazard_o         (hazard_o),
    .wb_res_o         (wb_res_o),
    .wb_rf_we_o       (wb_rf_we_o),
    .wb_rf_waddr_o    (wb_rf_waddr_o),
    .tkbr_o           (tkbr_o),
    .new_pc_o         (new_pc_o),
    .bus_err_o        (bus_err_o),
    .misaligned_o     (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] res;
    logic [4:0]  waddr;
    logic        tk;
    logic [31:0] pc;
    logic        berr;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  task automatic push_wb(input logic we, input logic [31:0] res, input logic [4:0] wa,
                         input logic tk, input logic [31:0] pc, input logic berr);
    wb_t e;
    e.we = we; e.res = res; e.waddr = wa; e.tk = tk; e.pc = pc; e.berr = berr;
    wb_q.push_back(e);
  endtask

  task automatic push_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  // Monitor: compares every presented request and writeback event.
  initial begin : monitor
    logic req_prev;
    req_t cur;
    wb_t  e;
    req_prev = 1'b0;
    cur.addr = '0; cur.we = 1'b0; cur.be = '0; cur.wdata = '0;
    forever begin
      @(negedge clk_i);
      if (!rsn_i) begin
        req_prev = 1'b0;
      end else begin
        if (mem_req_o) begin
          if (!req_prev) begin
            if (req_q.size() == 0) begin
              fail("req_unexpected");
            end else begin
              cur = req_q.pop_front();
              check("req_addr",  mem_addr_o,  cur.addr);
              check("req_we",    32'(mem_we_o), 32'(cur.we));
              check("req_be",    32'(mem_be_o), 32'(cur.be));
              check("req_wdata", mem_wdata_o, cur.wdata);
            end
          end else begin
            check("req_stable",
                  32'((mem_addr_o == cur.addr) && (mem_we_o == cur.we) &&
                      (mem_be_o == cur.be) && (mem_wdata_o == cur.wdata)), 32'd1);
          end
        end
        req_prev = mem_req_o;
        if (wb_rf_we_o || tkbr_o || bus_err_o) begin
          if (wb_q.size() == 0) begin
            fail("wb_unexpected");
          end else begin
            e = wb_q.pop_front();
            check("wb_we",   32'(wb_rf_we_o), 32'(e.we));
            check("wb_tkbr", 32'(tkbr_o),     32'(e.tk));
            check("wb_berr", 32'(bus_err_o),  32'(e.berr));
            if (e.we) begin
              check("wb_res",   wb_res_o,           e.res);
              check("wb_waddr", 32'(wb_rf_waddr_o), 32'(e.waddr));
            end
            if (e.tk) check("wb_new_pc", new_pc_o, e.pc);
          end
        end
      end
    end
  end

  task automatic drive_clear();
    alu_res_i        = '0;
    rf_we_i          = 1'b0;
    rf_waddr_i       = '0;
    rf_st_data_i     = '0;
    memop_type_i     = BYTE;
    memop_rd_i       = 1'b0;
    memop_wr_i       = 1'b0;
    memop_sign_ext_i = 1'b0;
    tkbr_i           = 1'b0;
    new_pc_i         = '0;
    mem_rdata_i      = '0;
    mem_ack_i        = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic we, input logic [4:0] wa,
                        input logic tk, input logic [31:0] pc);
    alu_res_i  = res;
    rf_we_i    = we;
    rf_waddr_i = wa;
    tkbr_i     = tk;
    new_pc_i   = pc;
    if (we || tk) push_wb(we, res, wa, tk, pc, 1'b0);
    @(negedge clk_i);
    check("alu_hazard", 32'(hazard_o), 32'd0);
    @(posedge clk_i); #1;
    drive_clear();
  endtask

  // ack_at: REQ cycles without ack before the ack cycle; -1 = never ack.
  task automatic mem_op(input string name, input logic rd, input logic wr,
                        input memop_type_e ty, input logic sx,
                        input logic [31:0] addr, input logic [31:0] st,
                        input logic [4:0] wa, input int ack_at, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_res);
    int   n_haz;
    int   n_req;
    logic done;
    push_req({addr[31:2], 2'b00}, wr, exp_be, exp_wdata);
    if (ack_at < 0)   push_wb(1'b0, '0, '0, 1'b0, '0, 1'b1);
    else if (!wr)     push_wb(1'b1, exp_res, wa, 1'b0, '0, 1'b0);
    alu_res_i        = addr;
    rf_st_data_i     = st;
    rf_waddr_i       = wa;
    memop_type_i     = ty;
    memop_rd_i       = rd;
    memop_wr_i       = wr;
    memop_sign_ext_i = sx;
    n_haz = 0;
    n_req = 0;
    done  = 1'b0;
    @(negedge clk_i);
    if (hazard_o) n_haz++;
    @(posedge clk_i); #1;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ack_i   = (c == ack_at);
      mem_rdata_i = (c == ack_at) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk_i);
      if (hazard_o) n_haz++;
      else done = 1'b1;
      if (mem_req_o) n_req++;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    if (!done) fail({name, "_stall_never_released"});
    drive_clear();
    check({name, "_hazard_cycles"}, 32'(n_haz), 32'(1 + ((ack_at < 0) ? TO - 1 : ack_at)));
    check({name, "_req_cycles"},    32'(n_req), 32'((ack_at < 0) ? TO : ack_at + 1));
    if (wr || ack_at < 0) check({name, "_no_wb"}, 32'(wb_rf_we_o), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rsn_i = 1'b0;
    drive_clear();
    repeat (2) @(negedge clk_i);
    check("rst_mem_req",  32'(mem_req_o),    32'd0);
    check("rst_hazard",   32'(hazard_o),     32'd0);
    check("rst_wb_res",   wb_res_o,          32'd0);
    check("rst_wb_we",    32'(wb_rf_we_o),   32'd0);
    check("rst_tkbr",     32'(tkbr_o),       32'd0);
    check("rst_bus_err",  32'(bus_err_o),    32'd0);
    check("rst_misalign", 32'(misaligned_o), 32'd0);
    @(posedge clk_i); #1;
    rsn_i = 1'b1;

    // Pass-through ops, including back-to-back and a branch redirect.
    alu_op(32'h0000_0012, 1'b1, 5'd5,  1'b0, 32'h0);
    alu_op(32'h0000_DEAD, 1'b1, 5'd31, 1'b0, 32'h0);
    alu_op(32'h0000_0000, 1'b0, 5'd0,  1'b1, 32'h0000_0400);

    // Loads: ack at 3 coincides with the timeout count, ack must win.
    mem_op("lb_sx",  1, 0, BYTE, 1, 32'h1003, 32'h0, 5'd7,  3, 32'h80FF_FFFF,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op("lhu",    1, 0, HALF, 0, 32'h1002, 32'h0, 5'd8,  0, 32'hF00D_1234,
           4'b1100, 32'h0, 32'h0000_F00D);
    mem_op("lh_sx",  1, 0, HALF, 1, 32'h1000, 32'h0, 5'd9,  1, 32'h1234_8001,
           4'b0011, 32'h0, 32'hFFFF_8001);
    mem_op("lbu",    1, 0, BYTE, 0, 32'h1001, 32'h0, 5'd10, 2, 32'h0000_A500,
           4'b0010, 32'h0, 32'h0000_00A5);
    mem_op("lw",     1, 0, WORD, 0, 32'h4000, 32'h0, 5'd11, 0, 32'hCAFE_BABE,
           4'b1111, 32'h0, 32'hCAFE_BABE);

    // Stores.
    mem_op("sh",     0, 1, HALF, 0, 32'h2002, 32'h0000_BEEF, 5'd0, 0, 32'h0,
           4'b1100, 32'hBEEF_BEEF, 32'h0);
    mem_op("sb",     0, 1, BYTE, 0, 32'h5001, 32'h1234_56AB, 5'd0, 1, 32'h0,
           4'b0010, 32'hABAB_ABAB, 32'h0);
    mem_op("sw",     0, 1, WORD, 0, 32'h6000, 32'h1122_3344, 5'd0, 2, 32'h0,
           4'b1111, 32'h1122_3344, 32'h0);
    mem_op("rdwr",   1, 1, WORD, 0, 32'h8000, 32'hA5A5_A5A5, 5'd12, 0, 32'h0,
           4'b1111, 32'hA5A5_A5A5, 32'h0);

    // Misaligned word is issued with low bits ignored.
    mem_op("lw_mis", 1, 0, WORD, 0, 32'h3001, 32'h0, 5'd13, 0, 32'h5566_7788,
           4'b1111, 32'h0, 32'h5566_7788);
    check("misaligned_low", 32'(misaligned_o), 32'd0);

    // Timeout with no ack.
    mem_op("lw_to",  1, 0, WORD, 0, 32'h7004, 32'h0, 5'd14, -1, 32'h0,
           4'b1111, 32'h0, 32'h0);

    // Reset while a load waits.
    alu_op(32'h0000_ABCD, 1'b1, 5'd2, 1'b0, 32'h0);
    push_req(32'h9000, 1'b0, 4'b1111, 32'h0);
    alu_res_i    = 32'h9000;
    memop_rd_i   = 1'b1;
    memop_type_i = WORD;
    rf_waddr_i   = 5'd9;
    @(posedge clk_i); #1;
    @(posedge clk_i); #3;
    rsn_i = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req_o),  32'd0);
    check("midrst_hazard",  32'(hazard_o),   32'd0);
    check("midrst_wb_res",  wb_res_o,        32'd0);
    check("midrst_wb_we",   32'(wb_rf_we_o), 32'd0);
    drive_clear();
    @(posedge clk_i); #1;
    rsn_i = 1'b1;
    alu_op(32'h0000_0077, 1'b1, 5'd3, 1'b1, 32'h0000_0100);

    repeat (3) @(posedge clk_i);
    #1;
    check("wb_queue_drained",  32'(wb_q.size()),  32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
